// File: rtl/clb_pkg.sv
// Shared definitions for the parametrised CLB tile.
//   clb_state_t : configuration FSM state (UNCONFIG, LOAD, RUN)
//   CTRL_*      : bit positions of the per-LE control field that sits above
//                 the LUT bits in each configuration frame
//   CTRL_W      : width of that control field
package clb_pkg;

  typedef enum logic [1:0] {
    UNCONFIG = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } clb_state_t;

  localparam int CTRL_W       = 4;
  localparam int CTRL_OUT_REG = 0;  // 0: output is the LUT, 1: output is the flop
  localparam int CTRL_INIT    = 1;  // value loaded into the flop at config end / on SR
  localparam int CTRL_SR_EN   = 2;  // honour the global SR input
  localparam int CTRL_CE_EN   = 3;  // honour the global CE input

endpackage

// File: rtl/clb_le.sv
// One logic element: a LUT_K-input LUT, a D flop with set/reset-to-init and
// clock-enable, and an output select between the LUT and the flop.
//   clk, rst    : tile clock, asynchronous active-high reset (flop -> 0)
//   frame       : this LE's configuration bits (LUT in the low bits, ctrl above)
//   sel         : LUT inputs
//   ce, sr      : global clock enable / sync set-reset, gated by ctrl enables
//   run         : tile stays in RUN across this edge; otherwise the flop clears
//   load_done   : this edge completes a configuration load
//   load_init   : init bit of the frame as it will be after this edge
//   out         : ungated LE output (the top forces it to 0 outside RUN)
module clb_le
  import clb_pkg::*;
#(
  parameter int LUT_K = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2**LUT_K+CTRL_W-1:0]    frame,
  input  logic [LUT_K-1:0]              sel,
  input  logic                          ce,
  input  logic                          sr,
  input  logic                          run,
  input  logic                          load_done,
  input  logic                          load_init,
  output logic                          out
);

  localparam int LUT_D = 2**LUT_K;

  logic [LUT_D-1:0]  lut;
  logic [CTRL_W-1:0] ctrl;
  logic              f;
  logic              q;

  assign lut  = frame[LUT_D-1:0];
  assign ctrl = frame[LUT_D +: CTRL_W];
  assign f    = lut[sel];

  // Priority: config completion, then SR, then CE hold, then LUT capture.
  // Outside RUN the flop is held at 0 so a reconfiguration never exposes
  // stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (load_done) begin
      q <= load_init;
    end else if (run) begin
      if (ctrl[CTRL_SR_EN] && sr) begin
        q <= ctrl[CTRL_INIT];
      end else if (ctrl[CTRL_CE_EN] && !ce) begin
        q <= q;
      end else begin
        q <= f;
      end
    end else begin
      q <= 1'b0;
    end
  end

  assign out = ctrl[CTRL_OUT_REG] ? q : f;

endmodule

// File: rtl/clb_param.sv
// Parametrised CLB tile: NUM_LE logic elements configured from a serial chain.
//   K        : clock, rising edge
//   RST      : asynchronous active-high reset
//   CFG_EN   : configuration shift enable (held high for a whole load)
//   CFG_DIN  : configuration serial data
//   CFG_DOUT : last bit of the chain, for cascading into the next tile
//   CFG_DONE : high while the tile is configured and running
//   CFG_ERR  : one-cycle pulse when a load is abandoned early
//   IN       : LUT inputs, LE i uses IN[i*LUT_K +: LUT_K]
//   CE, SR   : global clock enable / sync set-reset-to-init
//   O        : LE outputs, forced to 0 unless running
module clb_param
  import clb_pkg::*;
#(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                      K,
  input  logic                      RST,
  input  logic                      CFG_EN,
  input  logic                      CFG_DIN,
  output logic                      CFG_DOUT,
  output logic                      CFG_DONE,
  output logic                      CFG_ERR,
  input  logic [NUM_LE*LUT_K-1:0]   IN,
  input  logic                      CE,
  input  logic                      SR,
  output logic [NUM_LE-1:0]         O
);

  localparam int LUT_D   = 2**LUT_K;
  localparam int FRAME_W = LUT_D + CTRL_W;
  localparam int TOTAL_W = NUM_LE * FRAME_W;
  localparam int CNT_W   = $clog2(TOTAL_W + 1);

  clb_state_t         state;
  logic [TOTAL_W-1:0] cfg_sr;
  logic [TOTAL_W-1:0] cfg_next;
  logic [CNT_W-1:0]   count;
  logic               load_done;
  logic               run;
  logic [NUM_LE-1:0]  le_out;

  assign cfg_next  = {cfg_sr[TOTAL_W-2:0], CFG_DIN};

  // The edge that shifts the final bit of a frame.
  assign load_done = (state == LOAD) && CFG_EN && (count == CNT_W'(TOTAL_W - 1));

  // Running across this edge; raising CFG_EN in RUN starts a reload.
  assign run       = (state == RUN) && !CFG_EN;

  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state   <= UNCONFIG;
      cfg_sr  <= '0;
      count   <= '0;
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= 1'b0;
      // The chain shifts in every state so cascaded tiles keep passing data.
      if (CFG_EN) begin
        cfg_sr <= cfg_next;
      end
      case (state)
        UNCONFIG: begin
          if (CFG_EN) begin
            state <= LOAD;
            count <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (!CFG_EN) begin
            state   <= UNCONFIG;
            count   <= '0;
            CFG_ERR <= 1'b1;
          end else if (load_done) begin
            state <= RUN;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RUN: begin
          if (CFG_EN) begin
            state <= LOAD;
            count <= CNT_W'(1);
          end
        end
        default: begin
          state <= UNCONFIG;
          count <= '0;
        end
      endcase
    end
  end

  assign CFG_DOUT = cfg_sr[TOTAL_W-1];
  assign CFG_DONE = (state == RUN);

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    // The init bit is tapped from the post-shift frame so the flop picks up
    // the value that includes the bit arriving on the completing edge.
    clb_le #(
      .LUT_K(LUT_K)
    ) u_le (
      .clk       (K),
      .rst       (RST),
      .frame     (cfg_sr[i*FRAME_W +: FRAME_W]),
      .sel       (IN[i*LUT_K +: LUT_K]),
      .ce        (CE),
      .sr        (SR),
      .run       (run),
      .load_done (load_done),
      .load_init (cfg_next[i*FRAME_W + LUT_D + CTRL_INIT]),
      .out       (le_out[i])
    );
  end

  assign O = (state == RUN) ? le_out : '0;

endmodule

// File: tb/tb_clb_param.sv
module tb_clb_param;

  localparam int LUT_K   = 4;
  localparam int NUM_LE  = 2;
  localparam int TOTAL_W = 40;

  logic       K = 1'b0;
  logic       RST;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       CFG_DOUT;
  logic       CFG_DONE;
  logic       CFG_ERR;
  logic [7:0] IN;
  logic       CE;
  logic       SR;
  logic [1:0] O;

  clb_param #(
    .LUT_K (LUT_K),
    .NUM_LE(NUM_LE)
  ) dut (
    .K       (K),
    .RST     (RST),
    .CFG_EN  (CFG_EN),
    .CFG_DIN (CFG_DIN),
    .CFG_DOUT(CFG_DOUT),
    .CFG_DONE(CFG_DONE),
    .CFG_ERR (CFG_ERR),
    .IN      (IN),
    .CE      (CE),
    .SR      (SR),
    .O       (O)
  );

  always #5 K = ~K;

  typedef enum int {E_O, E_DONE, E_ERR, E_DOUT} kind_t;
  typedef struct {
    string      tag;
    kind_t      kind;
    logic [1:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] model_sr;

  task automatic chk(input string tag, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input kind_t kind, input logic [1:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        E_O:    chk(e.tag, O, e.val);
        E_DONE: chk(e.tag, {1'b0, CFG_DONE}, e.val);
        E_ERR:  chk(e.tag, {1'b0, CFG_ERR}, e.val);
        default: chk(e.tag, {1'b0, CFG_DOUT}, e.val);
      endcase
    end
  endtask

  function automatic logic [39:0] mk(input logic [3:0] c1, input logic [15:0] l1,
                                     input logic [3:0] c0, input logic [15:0] l0);
    return {c1, l1, c0, l0};
  endfunction

  // Combinational-mode reference: each LE output is its LUT indexed by its IN nibble.
  function automatic logic [1:0] comb_o(input logic [39:0] f, input logic [7:0] in_v);
    logic [15:0] l1;
    logic [15:0] l0;
    l1 = f[35:20];
    l0 = f[15:0];
    return {l1[in_v[7:4]], l0[in_v[3:0]]};
  endfunction

  task automatic step();
    @(posedge K);
    #1;
  endtask

  // Shift the first n bits of v (MSB first). Leaves CFG_EN high.
  task automatic send(input logic [39:0] v, input int n, input bit full, input string tag);
    for (int k = 0; k < n; k++) begin
      CFG_EN   = 1'b1;
      CFG_DIN  = v[39-k];
      model_sr = {model_sr[38:0], v[39-k]};
      step();
      push_exp({tag, "_dout"}, E_DOUT, {1'b0, model_sr[39]});
      if (full && (k == n - 1)) begin
        push_exp({tag, "_done"}, E_DONE, 2'b01);
      end else begin
        push_exp({tag, "_busy"}, E_DONE, 2'b00);
        push_exp({tag, "_ogate"}, E_O, 2'b00);
      end
      drain();
    end
  endtask

  task automatic run_step(input logic sr_v, input logic ce_v, input logic [1:0] exp_o,
                          input string tag);
    SR = sr_v;
    CE = ce_v;
    step();
    push_exp(tag, E_O, exp_o);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] f1, f2, f3a, f3b, f5, ones;
    logic [7:0]  pats[3];

    f1   = mk(4'b0000, 16'h6996, 4'b0000, 16'h8000);
    f2   = mk(4'b0000, 16'h0000, 4'b0011, 16'h0000);
    f3a  = mk(4'b0001, 16'hFFFF, 4'b1111, 16'hFFFF);
    f3b  = mk(4'b0001, 16'hFFFF, 4'b1101, 16'hFFFF);
    f5   = mk(4'b0000, 16'h0001, 4'b0000, 16'hFFFE);
    ones = '1;
    pats[0] = 8'hF1;
    pats[1] = 8'hEF;
    pats[2] = 8'h3F;

    RST = 1'b1; CFG_EN = 1'b0; CFG_DIN = 1'b0; CE = 1'b1; SR = 1'b0; IN = 8'h00;
    model_sr = '0;
    #12;
    push_exp("rst_o", E_O, 2'b00);
    push_exp("rst_done", E_DONE, 2'b00);
    push_exp("rst_err", E_ERR, 2'b00);
    push_exp("rst_dout", E_DOUT, 2'b00);
    drain();
    RST = 1'b0;
    step();

    // 1: combinational XOR / AND
    send(f1, TOTAL_W, 1'b1, "t1");
    CFG_EN = 1'b0;
    foreach (pats[i]) begin
      IN = pats[i];
      #1;
      push_exp($sformatf("t1_comb_%h", pats[i]), E_O, comb_o(f1, pats[i]));
      drain();
    end
    step();
    push_exp("t1_hold_done", E_DONE, 2'b01);
    push_exp("t1_noerr", E_ERR, 2'b00);
    push_exp("t1_hold_o", E_O, comb_o(f1, 8'h3F));
    drain();

    // 2: registered output with init=1, LUT all zero
    send(f2, TOTAL_W, 1'b1, "t2");
    push_exp("t2_init", E_O, 2'b01);
    drain();
    CFG_EN = 1'b0;
    step();
    push_exp("t2_capture", E_O, 2'b00);
    drain();

    // 3: SR/CE priority; LE1 has SR/CE disabled, registered, LUT all ones
    send(f3a, TOTAL_W, 1'b1, "t3a");
    push_exp("t3a_init", E_O, 2'b01);
    drain();
    CFG_EN = 1'b0;
    run_step(1'b1, 1'b0, 2'b11, "t3a_sr_init1");
    send(f3b, TOTAL_W, 1'b1, "t3b");
    push_exp("t3b_init", E_O, 2'b00);
    drain();
    CFG_EN = 1'b0;
    run_step(1'b1, 1'b0, 2'b10, "t3b_sr_init0");
    run_step(1'b0, 1'b0, 2'b10, "t3b_ce_hold");
    run_step(1'b0, 1'b1, 2'b11, "t3b_ce_load");
    run_step(1'b1, 1'b1, 2'b10, "t3b_sr_over_ce");
    SR = 1'b0; CE = 1'b1;

    // 4: abort after 25 bits, then a clean load
    send(f1, 25, 1'b0, "t4");
    CFG_EN = 1'b0;
    step();
    push_exp("t4_err", E_ERR, 2'b01);
    push_exp("t4_done", E_DONE, 2'b00);
    push_exp("t4_o", E_O, 2'b00);
    drain();
    step();
    push_exp("t4_err_pulse", E_ERR, 2'b00);
    push_exp("t4_still_unconf", E_DONE, 2'b00);
    drain();
    send(f1, TOTAL_W, 1'b1, "t4re");
    CFG_EN = 1'b0;
    IN = 8'hEF;
    #1;
    push_exp("t4re_o", E_O, comb_o(f1, 8'hEF));
    drain();

    // 5: reconfiguration from RUN with O=11
    push_exp("t5_pre_o", E_O, 2'b11);
    drain();
    send(f5, TOTAL_W, 1'b1, "t5");
    CFG_EN = 1'b0;
    #1;
    push_exp("t5_new_ef", E_O, comb_o(f5, 8'hEF));
    drain();
    IN = 8'h00;
    #1;
    push_exp("t5_new_00", E_O, comb_o(f5, 8'h00));
    drain();

    // 6: cascade through back-to-back loads, then reset mid-load
    send(ones, TOTAL_W, 1'b1, "t6a");
    push_exp("t6a_o", E_O, 2'b11);
    drain();
    send(f1, 10, 1'b0, "t6b");
    RST = 1'b1;
    #1;
    model_sr = '0;
    push_exp("t6_rst_dout", E_DOUT, 2'b00);
    push_exp("t6_rst_o", E_O, 2'b00);
    push_exp("t6_rst_done", E_DONE, 2'b00);
    push_exp("t6_rst_err", E_ERR, 2'b00);
    drain();
    RST = 1'b0;
    CFG_EN = 1'b0;
    step();
    send(f1, TOTAL_W, 1'b1, "t6c");
    CFG_EN = 1'b0;
    IN = 8'h3F;
    #1;
    push_exp("t6c_o", E_O, comb_o(f1, 8'h3F));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
